// File: rtl/axi_decerr_slave.sv
// -----------------------------------------------------------------------------
// axi_decerr_slave
//   Default (no-match) port of the SoC crossbar. Every transaction routed here
//   has no home in the address map, so it is completed with DECERR, which keeps
//   the masters from hanging. The write and read paths are independent. Each
//   path holds one outstanding transaction. The block also keeps a sticky log of
//   the first faulting address, plus a saturating count of accepted AW/AR.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   aw_* / w_* / b_*          write address, data (payload ignored), response
//   ar_* / r_*                read address, read data (constant RespData)
//   fault_valid_o             sticky flag: a fault address is logged
//   fault_write_o             logged fault came from the write channel
//   fault_addr_o              logged fault address
//   fault_clr_i               clears fault_valid_o (a same-cycle capture wins)
//   err_cnt_o                 saturating count of AW + AR handshakes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module axi_decerr_slave #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned CntWidth  = 16,
  parameter logic [DataWidth-1:0] RespData = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // write address
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  // write data
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  // write response
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  // read address
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  // read data
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  // fault log and counter
  output logic                 fault_valid_o,
  output logic                 fault_write_o,
  output logic [AddrWidth-1:0] fault_addr_o,
  input  logic                 fault_clr_i,
  output logic [CntWidth-1:0]  err_cnt_o
);

  localparam int unsigned SumWidth = CntWidth + 1;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}          r_state_e;

  w_state_e               w_state_q;
  logic                   w_ready_q;
  logic                   b_valid_q;
  logic [IdWidth-1:0]     b_id_q;

  r_state_e               r_state_q;
  logic                   r_valid_q;
  logic [IdWidth-1:0]     r_id_q;
  logic [7:0]             r_len_q;
  logic [7:0]             r_cnt_q;

  logic                   fault_valid_q, fault_valid_d;
  logic                   fault_write_q, fault_write_d;
  logic [AddrWidth-1:0]   fault_addr_q,  fault_addr_d;
  logic [CntWidth-1:0]    err_cnt_q,     err_cnt_d;
  logic [SumWidth-1:0]    cnt_sum;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Address channels are ready whenever their path is idle; the reset term
  // keeps them low while reset is held even though idle is the reset state.
  assign aw_ready_o = (w_state_q == W_IDLE) & ~rst_i;
  assign ar_ready_o = (r_state_q == R_IDLE) & ~rst_i;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i  & w_ready_q;
  assign b_hs  = b_valid_q  & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_q  & r_ready_i;

  // ---------------------------------------------------------------- write path
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          b_id_q    <= aw_id_i;
          w_ready_q <= 1'b1;
          w_state_q <= W_DRAIN;
        end
        // Beats are swallowed; only the last one moves us on.
        W_DRAIN: if (w_hs && w_last_i) begin
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
          w_state_q <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          b_valid_q <= 1'b0;
          w_state_q <= W_IDLE;
        end
        default: begin
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- read path
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_id_q    <= ar_id_i;
          r_len_q   <= ar_len_i;
          r_cnt_q   <= '0;
          r_valid_q <= 1'b1;
          r_state_q <= R_DATA;
        end
        // The counter stops at len, so len=255 yields 256 beats without wrapping.
        R_DATA: if (r_hs) begin
          if (r_cnt_q == r_len_q) begin
            r_valid_q <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            r_cnt_q <= r_cnt_q + 8'd1;
          end
        end
        default: begin
          r_valid_q <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------ fault log and counter
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_write_d = fault_write_q;
    fault_addr_d  = fault_addr_q;
    // A clear in the same cycle as a new fault still records that fault.
    // On a simultaneous AW and AR, the write is the one recorded.
    if ((aw_hs | ar_hs) & (~fault_valid_q | fault_clr_i)) begin
      fault_valid_d = 1'b1;
      fault_write_d = aw_hs;
      fault_addr_d  = aw_hs ? aw_addr_i : ar_addr_i;
    end else if (fault_clr_i) begin
      fault_valid_d = 1'b0;
    end
  end

  // One extra bit catches the carry so that +2 from all-ones-minus-1 saturates.
  assign cnt_sum   = {1'b0, err_cnt_q} + SumWidth'(aw_hs) + SumWidth'(ar_hs);
  assign err_cnt_d = cnt_sum[CntWidth] ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_valid_q <= 1'b0;
      fault_write_q <= 1'b0;
      fault_addr_q  <= '0;
      err_cnt_q     <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_write_q <= fault_write_d;
      fault_addr_q  <= fault_addr_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // ------------------------------------------------------------------- outputs
  assign w_ready_o     = w_ready_q;
  assign b_valid_o     = b_valid_q;
  assign b_id_o        = b_id_q;
  assign b_resp_o      = 2'b11;
  assign r_valid_o     = r_valid_q;
  assign r_id_o        = r_id_q;
  assign r_data_o      = RespData;
  assign r_resp_o      = 2'b11;
  assign r_last_o      = r_valid_q & (r_cnt_q == r_len_q);
  assign fault_valid_o = fault_valid_q;
  assign fault_write_o = fault_write_q;
  assign fault_addr_o  = fault_addr_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_decerr_slave
//   Directed scenarios with literal expectations. These are followed by
//   randomized traffic. All of it is checked every cycle against a
//   transaction-level model of the error slave. The counter is narrowed so that
//   saturation is reachable in a few thousand cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_decerr_slave;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int CW = 10;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [63:0] RESP = 64'hBADC_AB1E_BADC_AB1E;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          aw_valid_i = 1'b0, w_valid_i = 1'b0, w_last_i = 1'b0, b_ready_i = 1'b0;
  logic          ar_valid_i = 1'b0, r_ready_i = 1'b0, fault_clr_i = 1'b0;
  logic [IW-1:0] aw_id_i = '0, ar_id_i = '0;
  logic [AW-1:0] aw_addr_i = '0, ar_addr_i = '0;
  logic [7:0]    ar_len_i = '0;

  logic          aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
  logic [IW-1:0] b_id_o, r_id_o;
  logic [1:0]    b_resp_o, r_resp_o;
  logic [DW-1:0] r_data_o;
  logic          fault_valid_o, fault_write_o;
  logic [AW-1:0] fault_addr_o;
  logic [CW-1:0] err_cnt_o;

  axi_decerr_slave #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .fault_valid_o(fault_valid_o), .fault_write_o(fault_write_o), .fault_addr_o(fault_addr_o),
    .fault_clr_i(fault_clr_i), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- model state
  // Write: busy from AW acceptance until B is taken; last_seen once the final W arrived.
  bit          m_w_busy = 0, m_w_last_seen = 0;
  logic [IW-1:0] m_w_id = '0;
  // Read: busy from AR acceptance until the final beat is taken.
  bit          m_r_busy = 0;
  int          m_r_len = 0, m_r_sent = 0;
  logic [IW-1:0] m_r_id = '0;
  bit          m_f_valid = 0, m_f_write = 0;
  logic [63:0] m_f_addr = '0;
  int          m_cnt = 0;
  // Handshakes that occurred on the most recent clock edge.
  bit          hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    bit cap;
    if (rst_i) begin
      m_w_busy = 0; m_w_last_seen = 0; m_w_id = '0;
      m_r_busy = 0; m_r_len = 0; m_r_sent = 0; m_r_id = '0;
      m_f_valid = 0; m_f_write = 0; m_f_addr = '0; m_cnt = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      return;
    end
    hs_aw = aw_valid_i && !m_w_busy;
    hs_w  = w_valid_i && m_w_busy && !m_w_last_seen;
    hs_b  = b_ready_i && m_w_busy && m_w_last_seen;
    hs_ar = ar_valid_i && !m_r_busy;
    hs_r  = r_ready_i && m_r_busy;

    if (hs_b) begin
      $display("B  id=%02h resp=DECERR", m_w_id);
      m_w_busy = 0; m_w_last_seen = 0;
    end
    if (hs_w && w_last_i) m_w_last_seen = 1;
    if (hs_aw) begin m_w_busy = 1; m_w_last_seen = 0; m_w_id = aw_id_i; end

    if (hs_r) begin
      if (m_r_sent == m_r_len) begin
        $display("R  id=%02h beats=%0d resp=DECERR", m_r_id, m_r_len + 1);
        m_r_busy = 0;
      end else m_r_sent++;
    end
    if (hs_ar) begin m_r_busy = 1; m_r_len = int'(ar_len_i); m_r_sent = 0; m_r_id = ar_id_i; end

    cap = (hs_aw || hs_ar) && (!m_f_valid || fault_clr_i);
    if (cap) begin
      m_f_valid = 1; m_f_write = hs_aw;
      m_f_addr = hs_aw ? aw_addr_i : ar_addr_i;
    end else if (fault_clr_i) m_f_valid = 0;

    m_cnt = m_cnt + int'(hs_aw) + int'(hs_ar);
    if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
  endtask

  task automatic compare();
    chk("aw_ready", 64'(aw_ready_o), 64'(!rst_i && !m_w_busy));
    chk("w_ready",  64'(w_ready_o),  64'(m_w_busy && !m_w_last_seen));
    chk("b_valid",  64'(b_valid_o),  64'(m_w_busy && m_w_last_seen));
    if (m_w_busy && m_w_last_seen) begin
      chk("b_id",   64'(b_id_o),   64'(m_w_id));
      chk("b_resp", 64'(b_resp_o), 64'd3);
    end
    chk("ar_ready", 64'(ar_ready_o), 64'(!rst_i && !m_r_busy));
    chk("r_valid",  64'(r_valid_o),  64'(m_r_busy));
    chk("r_last",   64'(r_last_o),   64'(m_r_busy && (m_r_sent == m_r_len)));
    if (m_r_busy) begin
      chk("r_id",   64'(r_id_o),   64'(m_r_id));
      chk("r_data", 64'(r_data_o), RESP);
      chk("r_resp", 64'(r_resp_o), 64'd3);
    end
    chk("fault_valid", 64'(fault_valid_o), 64'(m_f_valid));
    if (m_f_valid) begin
      chk("fault_write", 64'(fault_write_o), 64'(m_f_write));
      chk("fault_addr",  64'(fault_addr_o),  m_f_addr);
    end
    chk("err_cnt", 64'(err_cnt_o), 64'(m_cnt));
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic rand_cycle();
    if (!aw_valid_i || hs_aw) begin
      aw_valid_i = ($urandom_range(0, 3) == 0);
      aw_id_i    = IW'($urandom);
      aw_addr_i  = {$urandom, $urandom};
    end
    if (!w_valid_i || hs_w) begin
      w_valid_i = 1'($urandom_range(0, 1));
      w_last_i  = ($urandom_range(0, 2) == 0);
    end
    b_ready_i = 1'($urandom_range(0, 1));
    if (!ar_valid_i || hs_ar) begin
      ar_valid_i = ($urandom_range(0, 3) == 0);
      ar_id_i    = IW'($urandom);
      ar_addr_i  = {$urandom, $urandom};
      ar_len_i   = ($urandom_range(0, 31) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
    end
    r_ready_i   = ($urandom_range(0, 3) != 0);
    fault_clr_i = ($urandom_range(0, 7) == 0);
    tick();
  endtask

  // Let pending requests land and every open transaction complete.
  task automatic drain();
    bit done = 0;
    fault_clr_i = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hs_aw) aw_valid_i = 0;
      if (hs_ar) ar_valid_i = 0;
      if (hs_w)  w_valid_i = 0;
      if (m_w_busy && !m_w_last_seen) begin w_valid_i = 1; w_last_i = 1; end
      b_ready_i = 1; r_ready_i = 1;
      if (!aw_valid_i && !ar_valid_i && !m_w_busy && !m_r_busy) begin done = 1; break; end
      tick();
    end
    w_valid_i = 0; w_last_i = 0; b_ready_i = 0; r_ready_i = 0;
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    int beats;
    // ------------------------------------------------------------------ reset
    @(negedge clk);
    tick();
    chk("rst_aw_ready", 64'(aw_ready_o), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
    chk("rst_b_valid",  64'(b_valid_o),  64'd0);
    chk("rst_r_valid",  64'(r_valid_o),  64'd0);
    chk("rst_r_last",   64'(r_last_o),   64'd0);
    chk("rst_ids",      64'({b_id_o, r_id_o}), 64'd0);
    chk("rst_fault",    64'({fault_valid_o, fault_write_o}), 64'd0);
    chk("rst_fault_addr", fault_addr_o, 64'd0);
    chk("rst_cnt",      64'(err_cnt_o),  64'd0);
    rst_i = 0;
    tick();
    chk("post_rst_ready", 64'({aw_ready_o, ar_ready_o}), 64'b11);

    // ------------------------------------------- single write, 4 beats
    aw_valid_i = 1; aw_id_i = 6'd5; aw_addr_i = 64'h6000_0000;
    tick();
    aw_valid_i = 0;
    chk("t1_cnt",        64'(err_cnt_o),     64'd1);
    chk("t1_fault_addr", fault_addr_o,       64'h6000_0000);
    chk("t1_fault_wr",   64'(fault_write_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      w_valid_i = 1; w_last_i = (k == 3);
      tick();
      if (k == 2) chk("t1_b_early", 64'(b_valid_o), 64'd0);
    end
    w_valid_i = 0; w_last_i = 0;
    chk("t1_b_valid", 64'(b_valid_o), 64'd1);
    chk("t1_b_id",    64'(b_id_o),    64'd5);
    chk("t1_b_resp",  64'(b_resp_o),  64'd3);
    b_ready_i = 1; tick(); b_ready_i = 0;
    chk("t1_b_done", 64'(b_valid_o), 64'd0);

    // ------------------------------------- read len=3 with toggling ready
    ar_valid_i = 1; ar_id_i = 6'h2A; ar_len_i = 8'd3; ar_addr_i = 64'h1234;
    tick();
    ar_valid_i = 0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      r_ready_i = (c % 2 == 0);
      if (r_valid_o && r_ready_i) begin
        chk("t2_last", 64'(r_last_o), 64'(beats == 3));
        chk("t2_data", 64'(r_data_o), RESP);
        chk("t2_id",   64'(r_id_o),   64'h2A);
        beats++;
      end
      tick();
    end
    r_ready_i = 0;
    chk("t2_beats", 64'(beats), 64'd4);
    chk("t2_done",  64'(r_valid_o), 64'd0);

    // ------------------------------ simultaneous AW and AR with empty log
    fault_clr_i = 1; tick(); fault_clr_i = 0;
    chk("t3_cleared", 64'(fault_valid_o), 64'd0);
    aw_valid_i = 1; aw_id_i = 6'h11; aw_addr_i = 64'h7000_0000;
    ar_valid_i = 1; ar_id_i = 6'h22; ar_addr_i = 64'h7100_0000; ar_len_i = 8'd0;
    tick();
    aw_valid_i = 0; ar_valid_i = 0;
    chk("t3_cnt",        64'(err_cnt_o),     64'd4);
    chk("t3_fault_addr", fault_addr_o,       64'h7000_0000);
    chk("t3_fault_wr",   64'(fault_write_o), 64'd1);
    chk("t3_r_last",     64'(r_last_o),      64'd1);
    w_valid_i = 1; w_last_i = 1; r_ready_i = 1;
    tick();
    w_valid_i = 0; w_last_i = 0; r_ready_i = 0;
    chk("t3_b_valid", 64'(b_valid_o), 64'd1);
    chk("t3_r_done",  64'(r_valid_o), 64'd0);
    b_ready_i = 1; tick(); b_ready_i = 0;

    // ------------------------------------- clear and capture in same cycle
    ar_valid_i = 1; ar_id_i = 6'd3; ar_addr_i = 64'h9000_0000; ar_len_i = 8'd0;
    fault_clr_i = 1;
    tick();
    ar_valid_i = 0; fault_clr_i = 0;
    chk("t4_fault_valid", 64'(fault_valid_o), 64'd1);
    chk("t4_fault_addr",  fault_addr_o,       64'h9000_0000);
    chk("t4_fault_wr",    64'(fault_write_o), 64'd0);
    chk("t4_cnt",         64'(err_cnt_o),     64'd5);
    r_ready_i = 1; tick(); r_ready_i = 0;
    // A later fault must not overwrite the held log.
    aw_valid_i = 1; aw_id_i = 6'd9; aw_addr_i = 64'hA000_0000;
    tick();
    aw_valid_i = 0;
    chk("t4_keep_addr", fault_addr_o, 64'h9000_0000);
    chk("t4_keep_wr",   64'(fault_write_o), 64'd0);
    chk("t4_cnt2",      64'(err_cnt_o), 64'd6);
    w_valid_i = 1; w_last_i = 1; tick(); w_valid_i = 0; w_last_i = 0;
    b_ready_i = 1; tick(); b_ready_i = 0;

    // ------------------------------------------------------ random traffic
    for (int c = 0; c < 1500; c++) rand_cycle();
    drain();

    // ------------------------------------------- reset in the middle of a burst
    ar_valid_i = 1; ar_id_i = 6'h15; ar_addr_i = 64'hDEAD_0000; ar_len_i = 8'd7;
    tick();
    ar_valid_i = 0; r_ready_i = 1;
    tick();
    chk("t6_beat2", 64'(r_valid_o), 64'd1);
    rst_i = 1; r_ready_i = 0;
    tick();
    chk("t6_valids",   64'({b_valid_o, r_valid_o, fault_valid_o}), 64'd0);
    chk("t6_readies",  64'({aw_ready_o, ar_ready_o}), 64'd0);
    chk("t6_cnt",      64'(err_cnt_o), 64'd0);
    rst_i = 0;
    tick();
    ar_valid_i = 1; ar_id_i = 6'h07; ar_len_i = 8'd0; ar_addr_i = 64'hBEEF_0000;
    tick();
    ar_valid_i = 0;
    chk("t6_r_valid", 64'(r_valid_o), 64'd1);
    chk("t6_r_last",  64'(r_last_o),  64'd1);
    chk("t6_r_id",    64'(r_id_o),    64'h07);
    r_ready_i = 1; tick(); r_ready_i = 0;
    chk("t6_r_done",  64'(r_valid_o), 64'd0);
    chk("t6_cnt1",    64'(err_cnt_o), 64'd1);

    // ----------------------------------------- counter saturation
    for (int c = 0; c < 5000 && m_cnt < CNT_MAX - 1; c++) begin
      ar_valid_i = !m_r_busy; ar_len_i = 8'd0; r_ready_i = 1;
      tick();
    end
    ar_valid_i = 0; r_ready_i = 1;
    tick();
    r_ready_i = 0;
    chk("t5_pre", 64'(err_cnt_o), 64'(CNT_MAX - 1));
    aw_valid_i = 1; aw_addr_i = 64'hC000_0000; ar_valid_i = 1; ar_addr_i = 64'hC100_0000;
    tick();
    aw_valid_i = 0; ar_valid_i = 0;
    chk("t5_sat", 64'(err_cnt_o), 64'(CNT_MAX));
    w_valid_i = 1; w_last_i = 1; r_ready_i = 1; tick();
    w_valid_i = 0; w_last_i = 0; r_ready_i = 0;
    b_ready_i = 1; tick(); b_ready_i = 0;
    ar_valid_i = 1; tick(); ar_valid_i = 0;
    chk("t5_hold", 64'(err_cnt_o), 64'(CNT_MAX));
    r_ready_i = 1; tick(); r_ready_i = 0;

    // ------------------------------------------------ random traffic at max
    for (int c = 0; c < 800; c++) rand_cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
